aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
- Sequential AES-128 key-schedule controller.
- On `start`, captures a cipher key and iterates the existing single-round expansion block `key` once per clock, for rounds 0..9.
- Stores all 11 round keys in an internal table. The cipher round engine reads them by index.
- Sits between key-load logic and the encrypt datapath. Only one expansion block is instantiated and shared across all rounds.

Parameters:
- KEY_SIZE, 128, cipher key width in bits; only 128 is supported.
- NUM_RK, 11, number of round keys stored (Nr+1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to expand `key_in`.
- key_in  input  128  cipher key, sampled in the `start` cycle.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when round key 10 has been written.
- keys_valid  output  1  high when the table holds a complete schedule.
- rd_idx  input  4  round-key index to read, 0..10.
- rd_key  output  128  registered read data.
- rd_ok  output  1  registered; high when `rd_key` is a valid round key.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; round counter rc=0.
  - All table entries, `rd_key`, `busy`, `done`, `keys_valid` and `rd_ok` are cleared to 0.
  - Reset mid-expansion aborts the expansion; no partial schedule survives.
- FSM states: IDLE, EXPAND, READY.
  - IDLE/READY + start=1: write `key_in` to slot 0, rc<=0, keys_valid<=0, busy<=1, go to EXPAND.
  - EXPAND: drive the expansion block with rc and k_in=slot[rc]; write k_out to slot[rc+1]; rc<=rc+1.
  - EXPAND when rc=9: after the write to slot 10, go to READY; busy<=0, keys_valid<=1, done<=1 for exactly one cycle.
  - READY + no start: hold.
- `start` while in EXPAND is ignored. No queuing, no restart.
- Latency: start sampled at edge T gives busy=1 after T. Slot n is written at edge T+n, for n=1..10. done=1 and keys_valid=1 are visible after edge T+10. Full expansion takes 11 cycles including the load.
- The rc fed to the expansion block is always 0..9; its rcon default branch is never exercised.
- Read port:
  - At each edge, rd_key<=slot[rd_idx] and rd_ok<=keys_valid && (rd_idx<=10). One-cycle read latency.
  - rd_idx 11..15: rd_key<=0, rd_ok<=0.
  - Reads during EXPAND return the current slot contents with rd_ok=0.
- Simultaneous events:
  - rst dominates start.
  - start in the same cycle as a READY-state read: the read returns the old slot data with rd_ok=1 for that cycle (keys_valid is still 1 at that edge). keys_valid drops to 0 from the next edge.
- Arithmetic: all XOR/S-box work is inside the expansion block. The controller only handles the 4-bit rc increment (0..9, no wrap) and indexing.

Optional Feature:
- Macro: AES_KEY_SCHED_ZEROIZE_EN.
- Defined:
  - Adds input port `zeroize` (1 bit).
  - zeroize=1 at an edge clears all 11 slots and rd_key to 0, forces keys_valid=0 and rd_ok=0, and returns the FSM to IDLE.
  - Priority order: rst > zeroize > start.
- Not defined: no `zeroize` port. Table contents persist until overwritten by the next start or cleared by rst.

Decomposition:
- Shared package aes_pkg holds:
  - localparam AES_NR=10 and AES_NUM_RK=11.
  - typedef aes_block_t (logic[127:0]).
  - typedef aes_rc_t (logic[3:0]).
  - typedef enum for FSM states {KS_IDLE, KS_EXPAND, KS_READY}.
- One sub-module: the existing round-key expansion block `key`, instantiated exactly once.
- Table, FSM and read register stay inline in aes_key_sched.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle:
  - done pulses exactly 10 cycles after the start edge.
  - Read idx 1 -> a0fafe1788542cb123a339392a6c7605, rd_ok=1.
  - Read idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, rd_ok=1.
- Key all-zero:
  - idx 0 -> 0.
  - idx 1 -> 62636363626363636263636362636363.
  - idx 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Assert start again 4 cycles into expansion with a different key:
  - Ignored; the final schedule matches the first key.
  - busy stays high for 10 cycles total.
- Assert rst at expansion cycle 5:
  - Next cycle: busy=0, keys_valid=0, every slot reads 0, rd_ok=0.
  - A subsequent start completes normally.
- In READY:
  - rd_idx=11 and rd_idx=15 -> rd_key=0, rd_ok=0.
  - rd_idx=0 -> key_in, rd_ok=1, with one-cycle latency.
- With AES_KEY_SCHED_ZEROIZE_EN defined: zeroize pulse in READY -> all slots read 0, keys_valid=0. Without the macro, the design compiles with no `zeroize` port.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key-schedule slice.
// Pure declarations; no logic, no latency.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_NUM_RK = 11;

    typedef logic [127:0] aes_block_t;
    typedef logic [3:0]   aes_rc_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_READY
    } ks_state_t;

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-load / round-key read bundle between key-load logic, the scheduler and the cipher engine.
// Optional zeroize wire exists only when AES_KEY_SCHED_ZEROIZE_EN is defined.
interface aes_key_sched_if;
    import aes_pkg::*;

    logic       start;
    aes_block_t key_in;
    logic       busy;
    logic       done;
    logic       keys_valid;
    aes_rc_t    rd_idx;
    aes_block_t rd_key;
    logic       rd_ok;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic       zeroize;
`endif

    modport master (
        output start, key_in, rd_idx,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        output zeroize,
`endif
        input  busy, done, keys_valid, rd_key, rd_ok
    );

    modport slave (
        input  start, key_in, rd_idx,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        input  zeroize,
`endif
        output busy, done, keys_valid, rd_key, rd_ok
    );

endinterface

// File: rtl/aes_key_sched_key.sv
// Single AES-128 key-expansion round: next round key from previous key and round index.
// Purely combinational, zero latency; no handshake.
module key
    import aes_pkg::*;
(
    input  aes_rc_t    rc,
    input  aes_block_t k_in,
    output aes_block_t k_out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    always_comb begin
        rcon = 8'h00;
        case (rc)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = k_in;
    // RotWord then SubWord on the last word, rcon folded into the top byte
    assign temp  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n0    = w0 ^ temp;
    assign n1    = w1 ^ n0;
    assign n2    = w2 ^ n1;
    assign n3    = w3 ^ n2;
    assign k_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key scheduler: 11-cycle sequential expansion into an 11-entry table, 1-cycle registered read.
// No backpressure: start ignored while busy. Optional zeroize port under AES_KEY_SCHED_ZEROIZE_EN.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_SIZE = 128,
    parameter int NUM_RK   = AES_NUM_RK
) (
    input  logic            clk,
    input  logic            rst,
    aes_key_sched_if.slave  ks
);

    localparam aes_rc_t LAST_IDX = aes_rc_t'(NUM_RK - 1);
    localparam aes_rc_t LAST_RC  = aes_rc_t'(AES_NR - 1);

    ks_state_t           state;
    aes_rc_t             rc;
    aes_rc_t             rc_nxt;
    logic [KEY_SIZE-1:0] tbl [NUM_RK];
    aes_block_t          k_cur;
    aes_block_t          k_out;
    logic                wipe;
    logic                idx_ok;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign wipe = rst || ks.zeroize;
`else
    assign wipe = rst;
`endif

    assign rc_nxt = rc + aes_rc_t'(1);
    assign k_cur  = tbl[rc];
    assign idx_ok = (ks.rd_idx <= LAST_IDX);

    key u_key (
        .rc    (rc),
        .k_in  (k_cur),
        .k_out (k_out)
    );

    always_ff @(posedge clk) begin
        if (wipe) begin
            state         <= KS_IDLE;
            rc            <= '0;
            ks.busy       <= 1'b0;
            ks.done       <= 1'b0;
            ks.keys_valid <= 1'b0;
            ks.rd_key     <= '0;
            ks.rd_ok      <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            ks.done   <= 1'b0;
            // Read samples pre-edge table and keys_valid, so a start coinciding with a read still returns old data
            ks.rd_key <= idx_ok ? tbl[ks.rd_idx] : '0;
            ks.rd_ok  <= ks.keys_valid && idx_ok;
            case (state)
                KS_IDLE, KS_READY: begin
                    if (ks.start) begin
                        tbl[0]        <= ks.key_in;
                        rc            <= '0;
                        ks.keys_valid <= 1'b0;
                        ks.busy       <= 1'b1;
                        state         <= KS_EXPAND;
                    end
                end
                KS_EXPAND: begin
                    tbl[rc_nxt] <= k_out;
                    if (rc == LAST_RC) begin
                        rc            <= '0;
                        ks.busy       <= 1'b0;
                        ks.keys_valid <= 1'b1;
                        ks.done       <= 1'b1;
                        state         <= KS_READY;
                    end else begin
                        rc <= rc_nxt;
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched;
    import aes_pkg::*;

    localparam aes_block_t K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t F_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam aes_block_t F_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam aes_block_t Z_RK1   = 128'h62636363626363636263636362636363;
    localparam aes_block_t Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst;
    int   npass = 0;
    int   ntot  = 0;
    int   cyc;
    int   bcnt;

    aes_key_sched_if ks_if ();

    aes_key_sched dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input int idx, input aes_block_t exp_key, input logic exp_ok);
        ks_if.rd_idx = aes_rc_t'(idx);
        step();
        chk({tag, "_key"}, ks_if.rd_key, exp_key);
        chk({tag, "_ok"}, {127'b0, ks_if.rd_ok}, {127'b0, exp_ok});
    endtask

    task automatic do_start(input aes_block_t k);
        ks_if.start  = 1'b1;
        ks_if.key_in = k;
        step();
        ks_if.start  = 1'b0;
    endtask

    // Steps until done, bounded; n and b carry cycles and busy-high samples since the start edge
    task automatic wait_done(input int n0, input int b0, output int n, output int b);
        n = n0;
        b = b0;
        while (ks_if.done !== 1'b1 && n < 20) begin
            step();
            n++;
            if (ks_if.busy === 1'b1) b++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        ks_if.start  = 1'b0;
        ks_if.key_in = '0;
        ks_if.rd_idx = '0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        ks_if.zeroize = 1'b0;
`endif
        step();
        step();
        chk("rst_busy", {127'b0, ks_if.busy}, 128'd0);
        chk("rst_done", {127'b0, ks_if.done}, 128'd0);
        chk("rst_kv", {127'b0, ks_if.keys_valid}, 128'd0);
        chk("rst_rd_ok", {127'b0, ks_if.rd_ok}, 128'd0);
        chk("rst_rd_key", ks_if.rd_key, 128'd0);
        rst = 1'b0;

        do_start(K_FIPS);
        chk("f_busy_start", {127'b0, ks_if.busy}, 128'd1);
        wait_done(0, 1, cyc, bcnt);
        chk("f_done_lat", 128'(cyc), 128'd10);
        chk("f_busy_len", 128'(bcnt), 128'd10);
        chk("f_kv", {127'b0, ks_if.keys_valid}, 128'd1);
        step();
        chk("f_done_pulse", {127'b0, ks_if.done}, 128'd0);
        rd("f_idx0", 0, K_FIPS, 1'b1);
        rd("f_idx1", 1, F_RK1, 1'b1);
        rd("f_idx10", 10, F_RK10, 1'b1);

        // Start coincident with a READY read, then a second start 4 cycles in that must be ignored
        ks_if.rd_idx = 4'd1;
        do_start('0);
        chk("coinc_key", ks_if.rd_key, F_RK1);
        chk("coinc_ok", {127'b0, ks_if.rd_ok}, 128'd1);
        chk("coinc_kv", {127'b0, ks_if.keys_valid}, 128'd0);
        bcnt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ks_if.busy === 1'b1) bcnt++;
        end
        do_start(K_FIPS);
        if (ks_if.busy === 1'b1) bcnt++;
        wait_done(4, bcnt, cyc, bcnt);
        chk("z_done_lat", 128'(cyc), 128'd10);
        chk("z_busy_len", 128'(bcnt), 128'd10);
        rd("z_idx0", 0, '0, 1'b1);
        rd("z_idx1", 1, Z_RK1, 1'b1);
        rd("z_idx10", 10, Z_RK10, 1'b1);

        // Reset during expansion
        ks_if.rd_idx = 4'd0;
        do_start(K_FIPS);
        for (int i = 0; i < 5; i++) step();
        chk("exp_rd_key", ks_if.rd_key, K_FIPS);
        chk("exp_rd_ok", {127'b0, ks_if.rd_ok}, 128'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {127'b0, ks_if.busy}, 128'd0);
        chk("abort_kv", {127'b0, ks_if.keys_valid}, 128'd0);
        chk("abort_done", {127'b0, ks_if.done}, 128'd0);
        for (int i = 0; i < 11; i++) begin
            rd($sformatf("abort_idx%0d", i), i, '0, 1'b0);
        end

        do_start(K_FIPS);
        wait_done(0, 1, cyc, bcnt);
        chk("r_done_lat", 128'(cyc), 128'd10);
        rd("r_idx10", 10, F_RK10, 1'b1);
        rd("r_idx11", 11, '0, 1'b0);
        rd("r_idx15", 15, '0, 1'b0);
        rd("r_idx0", 0, K_FIPS, 1'b1);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
        ks_if.zeroize = 1'b1;
        step();
        ks_if.zeroize = 1'b0;
        chk("zz_kv", {127'b0, ks_if.keys_valid}, 128'd0);
        chk("zz_rd_key", ks_if.rd_key, 128'd0);
        chk("zz_rd_ok", {127'b0, ks_if.rd_ok}, 128'd0);
        rd("zz_idx0", 0, '0, 1'b0);
        rd("zz_idx1", 1, '0, 1'b0);
        rd("zz_idx10", 10, '0, 1'b0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
